dpram_rr_arbiter: RTL
=====================

Name: dpram_rr_arbiter

Overview:
- Round-robin arbiter that shares one port of the team's dual-port RAM between N_REQ requesters in a single clock domain.
- Accepts read/write commands over valid/ready, drives the RAM port with registered we/addr/din, and returns read data to the issuing requester.
- Read data returns with a fixed latency, tracked by a tag pipeline.
- Sits between client engines (DMA, CPU bridge, etc.) and one DPRAM port. The other RAM port stays private to its owner.

Parameters:
N_REQ, 3, number of requesters (2..8)
DATA_WIDTH, 8, RAM data word width
ADDR_WIDTH, 4, RAM address width (2^ADDR_WIDTH words)

Ports:
clk  in  1  single clock; also drives the shared RAM port
rst_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester command valid
req_ready  out  N_REQ  one-hot grant/accept; combinational from req_valid and RR pointer
req_we  in  N_REQ  per-requester write enable (1=write, 0=read)
req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  N_REQ*DATA_WIDTH  packed write data, same packing
rsp_valid  out  N_REQ  one-hot read-data strobe, one cycle per read
rsp_data  out  DATA_WIDTH  shared read-data bus; meaningful only with rsp_valid
ram_we  out  1  registered RAM write enable
ram_addr  out  ADDR_WIDTH  registered RAM address
ram_din  out  DATA_WIDTH  registered RAM write data
ram_dout  in  DATA_WIDTH  RAM synchronous read output (1-cycle read)

Behaviour:
- Reset (async assert, sync-deassert by the integrator): ram_we=0, ram_addr=0, ram_din=0, rsp_valid=0, tag pipe cleared, last-grant pointer=N_REQ-1 (requester 0 wins first).
- Arbitration, each cycle:
  - Search req_valid starting at (last+1) mod N_REQ, wrapping.
  - First valid index g gets req_ready[g]=1; all other ready bits are 0. At most one grant per cycle.
  - Handshake occurs when req_valid[g]&&req_ready[g]; the pointer then updates to g.
  - No valid requests -> no grant, pointer held.
- Throughput: one command per cycle, no bubbles; back-to-back grants to different requesters are allowed.
- Command issue, cycle N handshake:
  - Cycle N+1: ram_we=req_we[g], ram_addr=req_addr[g], ram_din=req_wdata[g].
  - Cycle N+1 with no handshake at N: ram_we=0; addr/din hold their previous values.
- Read return:
  - Tag pipe stage1 (cycle N+1) = {read, g}; stage2 (cycle N+2) = stage1.
  - Cycle N+2: rsp_valid[g]=1 and rsp_data=ram_dout.
  - Writes never produce rsp_valid.
- RAM read-during-write on the same port returns old data (RAM's native behaviour); the arbiter adds no forwarding.
- No response backpressure: requesters must sink rsp_valid on the cycle it fires.
- Requester protocol: once req_valid is high, it must hold with stable we/addr/wdata until accepted. A drop before accept is legal (no command issued).
- Fairness: with all N_REQ continuously valid, grants rotate 0,1,..,N_REQ-1,0,…. Each requester waits at most N_REQ-1 cycles.
- Reset mid-operation: in-flight reads are discarded (no rsp_valid after release). A write already registered to the RAM port may complete; ram_we forced 0 immediately on assert.
- Other-port collisions are the system's responsibility; not detected here.

Optional Feature:
- Macro DPRAM_ARB_LOCK_EN.
- Defined: adds input req_lock [N_REQ]. If the last grantee has req_lock and req_valid both high, it is granted again regardless of RR order, pointer unchanged. This gives atomic read-modify-write or bursts. Lock from a non-last-grantee is ignored.
- Undefined: port absent; pure round-robin.

Decomposition:
- Package dpram_arb_pkg holds:
  - RD_LATENCY=2 (arbiter-to-response, cycles)
  - tag typedef {logic rd; logic [$clog2(N_REQ)-1:0] id}
  - the pack/unpack index helper function
- One sub-module: dpram_rr_grant, containing the pointer register plus the rotate-priority search (and the lock override). It outputs the one-hot grant and encoded index.
- The top holds the RAM port registers and the tag pipe.

Test Plan:
- After reset, req_valid=3'b111 all reads, held 6 cycles -> req_ready sequence 001,010,100,001,010,100; rsp_valid follows 2 cycles later in the same order.
- Req1 writes addr 4'h5 data 8'hA5; next cycle req2 reads addr 5 -> ram_we=1 one cycle after the write handshake; req2 rsp_valid[2]=1 with rsp_data=8'hA5, 2 cycles after its handshake.
- Only req2 valid for 4 cycles -> req_ready=100 every cycle; ram_addr changes each cycle; no idle cycles between commands.
- Idle: req_valid=0 -> ram_we=0, rsp_valid=0, pointer unchanged. A following single req0 read is accepted in the first cycle.
- Read accepted at cycle N, rst_n low at N+1 for 1 cycle -> rsp_valid stays 0 through N+4; ram_we=0 during reset; next grant goes to requester 0.
- DPRAM_ARB_LOCK_EN: req0 granted with lock=1, all three valid for 3 cycles -> req_ready=001,001,001. Lock drops -> next grant 010.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared constants, read-tag type and packed-bus slot helper for the DPRAM arbiter
package dpram_arb_pkg;
  localparam int RD_LATENCY = 2;
  localparam int N_REQ_MAX = 8;
  localparam int ID_W = $clog2(N_REQ_MAX);
  typedef struct packed {
    logic            rd;
    logic [ID_W-1:0] id;
  } tag_t;
  function automatic int slot_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/dpram_rr_grant.sv
// dpram_rr_grant: round-robin grant with last-grant pointer; DPRAM_ARB_LOCK_EN adds sticky lock
module dpram_rr_grant #(
  parameter int N_REQ = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
`ifdef DPRAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]         req_lock,
`endif
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_any
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] last_q, last_d, idx;
  // rotate-priority search from last+1, lock override, pointer next-state
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last_q;
    idx = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_q) + k) % N_REQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
`ifdef DPRAM_ARB_LOCK_EN
    if (req_lock[last_q] && req_valid[last_q]) begin
      gnt_any = 1'b1;
      gnt_idx = last_q;
    end
`endif
    gnt = gnt_any ? N_REQ'(1) << gnt_idx : '0;
    last_d = gnt_any ? gnt_idx : last_q;
  end
  // last-grant pointer; reset so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= IW'(N_REQ - 1);
    else last_q <= last_d;
endmodule

// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter: round-robin share of one DPRAM port; optional DPRAM_ARB_LOCK_EN lock input
module dpram_rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
`ifdef DPRAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]            req_lock,
`endif
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_din,
  input  logic [DATA_WIDTH-1:0]       ram_dout
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic gnt_any, sel_we, ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] sel_addr, ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] sel_din, ram_din_q, ram_din_d;
  tag_t tag_q [RD_LATENCY];
  tag_t tag_d [RD_LATENCY];
  dpram_rr_grant #(.N_REQ(N_REQ)) u_grant (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
`ifdef DPRAM_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );
  assign req_ready = gnt;
  assign rsp_data = ram_dout;
  assign ram_we = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din = ram_din_q;
  // pick the granted command, form next RAM port values and advance the read-tag pipe
  always_comb begin
    sel_we = 1'b0;
    sel_addr = '0;
    sel_din = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) begin
        sel_we = req_we[i];
        sel_addr = req_addr[slot_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
        sel_din = req_wdata[slot_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    ram_we_d = gnt_any & sel_we;
    ram_addr_d = gnt_any ? sel_addr : ram_addr_q;
    ram_din_d = gnt_any ? sel_din : ram_din_q;
    tag_d[0].rd = gnt_any & ~sel_we;
    tag_d[0].id = ID_W'(gnt_idx);
    for (int k = 1; k < RD_LATENCY; k++) tag_d[k] = tag_q[k-1];
  end
  // one-hot response strobe decoded from the last tag stage
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      rsp_valid[i] = tag_q[RD_LATENCY-1].rd && (tag_q[RD_LATENCY-1].id == ID_W'(i));
  end
  // RAM port registers and tag pipe; reset drops in-flight reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q <= ram_din_d;
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= tag_d[k];
    end
endmodule
